iir_biquad_cascade: RTL and testbench

Stereo, parametrised cascade of direct-form-I biquad sections sharing one time-multiplexed multiply-accumulate datapath. It sits between the I2S receive deserialiser and the transmit serialiser, and runs once per `l_r_clk` edge. Left and right channels keep fully independent filter history. Coefficients are runtime-writable through a shadow bank, so a filter can be retuned without glitching a computation in flight.

---
 rtl/iir_biquad_cascade.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - stereo cascade of direct-form-I biquads on one shared MAC
//
// Purpose: filters each I2S word (one per l_r_clk edge) through NUM_SECTIONS
// biquads. The left and right channels keep separate history. Coefficients are
// written to a shadow bank and copied to the active bank at the start of every
// sample, so a retune never disturbs a computation that is already running.
//
// Ports:
//   clk, reset        system clock; synchronous active-low reset
//   l_r_clk           asynchronous word select; each edge delivers one sample
//   sample_in         signed x[n] for the channel just selected
//   coef_wr_en        coefficient write strobe into the shadow bank
//   coef_wr_addr      5*s+k, where k = 0 b0, 1 b1, 2 b2, 3 a1, 4 a2
//   coef_wr_data      signed coefficient, COEF_FRAC fractional bits
//   sample_out        filtered y[n]
//   out_ch            channel of sample_out (0 left, 1 right)
//   out_valid         one-cycle pulse when sample_out/out_ch update
//   busy              high whenever the FSM is not idle
//   overrun           sticky; a pending sample was overwritten
//
// Build option: define IIR_SAT_EN to clamp every section output to the DATA_W
// range. Without it, each section output wraps to its low DATA_W bits.

module iir_biquad_cascade #(
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 16,
  parameter int COEF_FRAC    = 14,
  parameter int NUM_SECTIONS = 2,
  parameter int ACC_W        = 40
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              l_r_clk,
  input  logic [DATA_W-1:0]                 sample_in,
  input  logic                              coef_wr_en,
  input  logic [$clog2(5*NUM_SECTIONS)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]                 coef_wr_data,
  output logic [DATA_W-1:0]                 sample_out,
  output logic                              out_ch,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              overrun
);

  localparam int NC = 5 * NUM_SECTIONS;
  localparam int AW = $clog2(NC);
  localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0]     NC_A   = AW'(NC);
  localparam logic [SW-1:0]     S_LAST = SW'(NUM_SECTIONS - 1);
  localparam logic [COEF_W-1:0] UNITY  = COEF_W'(1) << COEF_FRAC;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  // Word-select synchroniser and edge detect
  logic sync_d1, sync_d2;
  logic lr_edge, edge_ch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_d1 <= 1'b0;
      sync_d2 <= 1'b0;
    end else begin
      sync_d1 <= l_r_clk;
      sync_d2 <= sync_d1;
    end
  end

  assign lr_edge = sync_d1 ^ sync_d2;
  assign edge_ch = sync_d1;

  // Coefficient banks
  logic [COEF_W-1:0] shadow    [NC];
  logic [COEF_W-1:0] shadow_nx [NC];
  logic [COEF_W-1:0] active    [NC];

  // The active copy takes shadow_nx, so a write in the LOAD cycle is included.
  always_comb begin
    shadow_nx = shadow;
    if (coef_wr_en && (coef_wr_addr < NC_A)) begin
      shadow_nx[coef_wr_addr] = coef_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        shadow[i] <= ((i % 5) == 0) ? UNITY : '0;
      end
    end else begin
      shadow <= shadow_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        active[i] <= ((i % 5) == 0) ? UNITY : '0;
      end
    end else if (state == LOAD) begin
      active <= shadow_nx;
    end
  end

  // Working registers and per-channel, per-section history
  logic signed [DATA_W-1:0] cur_x;
  logic                     cur_ch;
  logic signed [ACC_W-1:0]  acc;
  logic [SW-1:0]            s;
  logic [2:0]               k;
  logic                     pend_valid;
  logic [DATA_W-1:0]        pend_x;
  logic                     pend_ch;

  logic signed [DATA_W-1:0] hx1 [2][NUM_SECTIONS];
  logic signed [DATA_W-1:0] hx2 [2][NUM_SECTIONS];
  logic signed [DATA_W-1:0] hy1 [2][NUM_SECTIONS];
  logic signed [DATA_W-1:0] hy2 [2][NUM_SECTIONS];

  // FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (lr_edge) state_nx = LOAD;
      LOAD:    state_nx = MAC;
      MAC:     if (k == 3'd4) state_nx = STORE;
      STORE:   state_nx = (s == S_LAST) ? DONE : MAC;
      DONE:    state_nx = (pend_valid || lr_edge) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // MAC operand selection
  logic [SW-1:0]            s_prev;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] data_cur;
  logic [AW-1:0]            coef_idx;
  logic signed [COEF_W-1:0] coef_cur;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_nx;
  logic [DATA_W-1:0]        y_new;

  always_comb begin
    s_prev = s - SW'(1);
    // Section 0 filters the captured word; later sections filter the output
    // just stored by the section before them.
    x_in = (s == '0) ? cur_x : hy1[cur_ch][s_prev];
    case (k)
      3'd0:    data_cur = x_in;
      3'd1:    data_cur = hx1[cur_ch][s];
      3'd2:    data_cur = hx2[cur_ch][s];
      3'd3:    data_cur = hy1[cur_ch][s];
      3'd4:    data_cur = hy2[cur_ch][s];
      default: data_cur = '0;
    endcase
    coef_idx = AW'(5 * int'(s) + int'(k));
    coef_cur = (coef_idx < NC_A) ? $signed(active[coef_idx]) : '0;
    prod     = coef_cur * data_cur;
    prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    // Feedback terms a1, a2 are subtracted.
    acc_nx   = (k >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);
  end

  // Round half up: adding 2^(COEF_FRAC-1) before the shift equals adding bit
  // COEF_FRAC-1 of acc after it.
`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [ACC_W-1:0] scaled;

  always_comb begin
    acc_shr = acc >>> COEF_FRAC;
    scaled  = acc_shr + $signed({{(ACC_W - 1){1'b0}}, acc[COEF_FRAC-1]});
    if (scaled > SAT_MAX) begin
      y_new = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (scaled < SAT_MIN) begin
      y_new = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      y_new = scaled[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    y_new = acc[COEF_FRAC +: DATA_W] + DATA_W'(acc[COEF_FRAC-1]);
  end
`endif

  // Datapath, pending slot and outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_x      <= '0;
      cur_ch     <= 1'b0;
      acc        <= '0;
      s          <= '0;
      k          <= '0;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_ch    <= 1'b0;
      overrun    <= 1'b0;
      sample_out <= '0;
      out_ch     <= 1'b0;
      out_valid  <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < NUM_SECTIONS; i++) begin
          hx1[c][i] <= '0;
          hx2[c][i] <= '0;
          hy1[c][i] <= '0;
          hy2[c][i] <= '0;
        end
      end
    end else begin
      out_valid <= 1'b0;

      // Sample intake
      case (state)
        IDLE: begin
          if (lr_edge) begin
            cur_x  <= $signed(sample_in);
            cur_ch <= edge_ch;
          end
        end
        DONE: begin
          if (pend_valid) begin
            cur_x  <= $signed(pend_x);
            cur_ch <= pend_ch;
            // A word arriving while the pending one is consumed replaces it.
            pend_valid <= lr_edge;
            if (lr_edge) begin
              pend_x  <= sample_in;
              pend_ch <= edge_ch;
            end
          end else if (lr_edge) begin
            cur_x  <= $signed(sample_in);
            cur_ch <= edge_ch;
          end
        end
        default: begin
          if (lr_edge) begin
            if (pend_valid) overrun <= 1'b1;
            pend_valid <= 1'b1;
            pend_x     <= sample_in;
            pend_ch    <= edge_ch;
          end
        end
      endcase

      // Filter arithmetic
      case (state)
        LOAD: begin
          acc <= '0;
          s   <= '0;
          k   <= '0;
        end
        MAC: begin
          acc <= acc_nx;
          k   <= k + 3'd1;
        end
        STORE: begin
          hx2[cur_ch][s] <= hx1[cur_ch][s];
          hx1[cur_ch][s] <= x_in;
          hy2[cur_ch][s] <= hy1[cur_ch][s];
          hy1[cur_ch][s] <= $signed(y_new);
          if (s != S_LAST) begin
            s   <= s + SW'(1);
            acc <= '0;
            k   <= '0;
          end else begin
            sample_out <= y_new;
            out_ch     <= cur_ch;
            out_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - scoreboard bench for iir_biquad_cascade against a sample-level model

module tb_iir_biquad_cascade;

  localparam int NS   = 2;
  localparam int FRAC = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        l_r_clk;
  logic [15:0] sample_in;
  logic        coef_wr_en;
  logic [3:0]  coef_wr_addr;
  logic [15:0] coef_wr_data;
  logic [15:0] sample_out;
  logic        out_ch;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  iir_biquad_cascade dut (
    .clk          (clk),
    .reset        (reset),
    .l_r_clk      (l_r_clk),
    .sample_in    (sample_in),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .sample_out   (sample_out),
    .out_ch       (out_ch),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  // Reference model: one call filters one word through all sections.
  int mcoef [5*NS];
  int mx1 [2][NS];
  int mx2 [2][NS];
  int my1 [2][NS];
  int my2 [2][NS];

  function automatic void model_reset();
    for (int a = 0; a < 5*NS; a++) mcoef[a] = ((a % 5) == 0) ? (1 << FRAC) : 0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < NS; i++) begin
        mx1[c][i] = 0; mx2[c][i] = 0; my1[c][i] = 0; my2[c][i] = 0;
      end
  endfunction

  function automatic int model(input int ch, input int x);
    int     xs;
    int     y;
    longint acc;
    longint r;
    xs = x;
    for (int i = 0; i < NS; i++) begin
      acc = longint'(mcoef[5*i]) * xs
          + longint'(mcoef[5*i+1]) * mx1[ch][i]
          + longint'(mcoef[5*i+2]) * mx2[ch][i]
          - longint'(mcoef[5*i+3]) * my1[ch][i]
          - longint'(mcoef[5*i+4]) * my2[ch][i];
      r = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
`ifdef IIR_SAT_EN
      if (r > 32767) y = 32767;
      else if (r < -32768) y = -32768;
      else y = int'(r);
`else
      y = int'(shortint'(r));
`endif
      mx2[ch][i] = mx1[ch][i];
      mx1[ch][i] = xs;
      my2[ch][i] = my1[ch][i];
      my1[ch][i] = y;
      xs = y;
    end
    return xs;
  endfunction

  typedef struct {
    int ch;
    int val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;
  int   last_out   = 0;
  int   last_ch    = 0;
  logic lr         = 1'b0;

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (prev_valid) fail_now("out_valid_pulse_width");
      if (exp_q.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        mon_e = exp_q.pop_front();
        check("out_value", longint'($signed(sample_out)), mon_e.val);
        check("out_ch", longint'(out_ch), mon_e.ch);
      end
      last_out = int'($signed(sample_out));
      last_ch  = int'(out_ch);
    end
    prev_valid = out_valid;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    l_r_clk    = 1'b0;
    lr         = 1'b0;
    coef_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sample_out", longint'(sample_out), 0);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_overrun", longint'(overrun), 0);
    check("reset_out_ch", longint'(out_ch), 0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wr_coef(input int a, input int v);
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'(a);
    coef_wr_data = 16'(v);
    mcoef[a]     = v;
    @(negedge clk);
    coef_wr_en   = 1'b0;
  endtask

  // One word-select toggle; the channel is the new level of l_r_clk.
  task automatic send(input int x, input bit track);
    exp_t e;
    @(negedge clk);
    sample_in = 16'(x);
    lr        = ~lr;
    l_r_clk   = lr;
    if (track) begin
      e.ch  = int'(lr);
      e.val = model(int'(lr), x);
      exp_q.push_back(e);
    end
  endtask

  int imp_exp [4];
  int t_valid;
  int t1;
  int t2;
  int v;

  initial begin
    reset        = 1'b0;
    l_r_clk      = 1'b0;
    sample_in    = '0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    imp_exp      = '{8192, 4096, 2048, 1024};
    do_reset();

    // Passthrough and timing: the first toggle is a right word, then left 1000.
    send(0, 1'b1);
    wait_cyc(20);
    send(1000, 1'b1);
    t_valid = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid && t_valid < 0) t_valid = i;
      if (i == 1)  check("busy_before_load", longint'(busy), 0);
      if (i == 2)  check("busy_at_load", longint'(busy), 1);
      if (i == 15) check("busy_at_done", longint'(busy), 1);
      if (i == 16) check("busy_after_done", longint'(busy), 0);
    end
    check("output_latency", t_valid, 15);
    check("passthrough_value", last_out, 1000);
    check("passthrough_ch", last_ch, 0);

    // Impulse response on left, zeros on right
    do_reset();
    wr_coef(0, 8192);
    wr_coef(3, -8192);
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b1);
      wait_cyc(18);
      check("stereo_right_zero", last_out, 0);
      send((i == 0) ? 16384 : 0, 1'b1);
      wait_cyc(18);
      check("impulse_left", last_out, imp_exp[i]);
    end

    // Saturation / wrap
    do_reset();
    wr_coef(0, 32767);
    send(0, 1'b1);
    wait_cyc(18);
    send(30000, 1'b1);
    wait_cyc(18);
`ifdef IIR_SAT_EN
    check("saturation", last_out, 32767);
`else
    check("wrap", last_out, -5538);
`endif

    // Shadow write during a busy computation
    do_reset();
    send(0, 1'b1);
    wait_cyc(18);
    send(2000, 1'b1);
    wait_cyc(5);
    wr_coef(0, 8192);
    wait_cyc(15);
    check("shadow_old_coef", last_out, 2000);
    send(2000, 1'b1);
    wait_cyc(18);
    check("shadow_new_coef", last_out, 1000);

    // Overrun: three words two cycles apart, the middle one is lost
    do_reset();
    send(111, 1'b1);
    @(negedge clk);
    send(222, 1'b0);
    @(negedge clk);
    send(333, 1'b1);
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
      end
    end
    check("back_to_back_gap", t2 - t1, 14);
    check("overrun_set", longint'(overrun), 1);
    check("overrun_outputs", exp_q.size(), 0);
    check("overrun_last", last_out, 333);
    wait_cyc(10);
    check("overrun_sticky", longint'(overrun), 1);

    // Reset in the middle of a computation discards it
    send(500, 1'b0);
    wait_cyc(6);
    do_reset();
    wait_cyc(20);
    check("no_output_after_reset", exp_q.size(), 0);
    send(0, 1'b1);
    wait_cyc(18);
    send(700, 1'b1);
    wait_cyc(18);
    check("passthrough_after_reset", last_out, 700);

    // Randomised coefficients and samples on both channels
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 5*NS; a++) begin
        v = int'($urandom_range(0, 65535)) - 32768;
        wr_coef(a, v);
      end
      for (int j = 0; j < 10; j++) begin
        v = int'($urandom_range(0, 65535)) - 32768;
        send(v, 1'b1);
        wait_cyc(15 + int'($urandom_range(0, 5)));
      end
      wait_cyc(20);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
